// File: rtl/change_dispenser_pkg.sv
// Shared vending-machine definitions: coin count, amount width and denominations.
// The coin/timer logic uses the same constants, so change them here only.
package change_dispenser_pkg;

    localparam int unsigned kDefNumCoins  = 3;
    localparam int unsigned kDefTotalBits = 31;
    localparam int unsigned kDefCoinVal0  = 100;
    localparam int unsigned kDefCoinVal1  = 500;
    localparam int unsigned kDefCoinVal2  = 1000;

endpackage

// File: rtl/change_dispenser_coin_select.sv
// Combinational pick of the largest denomination that still fits in the owed amount.
module coin_select
    import change_dispenser_pkg::*;
#(
    parameter int unsigned kNumCoins  = kDefNumCoins,
    parameter int unsigned kTotalBits = kDefTotalBits,
    parameter int unsigned kCoinVal0  = kDefCoinVal0,
    parameter int unsigned kCoinVal1  = kDefCoinVal1,
    parameter int unsigned kCoinVal2  = kDefCoinVal2
) (
    input  logic [kTotalBits-1:0] remaining,
    output logic [kNumCoins-1:0]  coin,
    output logic                  valid
);

    // Priority chain from the largest coin down keeps the result one-hot.
    always_comb begin
        coin = '0;
        if (remaining >= kTotalBits'(kCoinVal2)) begin
            coin[2] = 1'b1;
        end else if (remaining >= kTotalBits'(kCoinVal1)) begin
            coin[1] = 1'b1;
        end else if (remaining >= kTotalBits'(kCoinVal0)) begin
            coin[0] = 1'b1;
        end
    end

    assign valid = |coin;

endmodule

// File: rtl/change_dispenser.sv
// Returns an amount as a greedy sequence of coins, one per hopper-ready cycle,
// then pulses o_done and leaves the undispensable residue on o_remaining.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int unsigned kNumCoins  = kDefNumCoins,
    parameter int unsigned kTotalBits = kDefTotalBits,
    parameter int unsigned kCoinVal0  = kDefCoinVal0,
    parameter int unsigned kCoinVal1  = kDefCoinVal1,
    parameter int unsigned kCoinVal2  = kDefCoinVal2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_start,
    input  logic [kTotalBits-1:0] i_amount,
    input  logic                  i_hopper_ready,
    output logic [kNumCoins-1:0]  o_return_coin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [kTotalBits-1:0] o_remaining
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        DONE     = 2'd2
    } state_t;

    state_t                state;
    logic [kNumCoins-1:0]  sel_coin;
    logic                  sel_valid;
    logic [kTotalBits-1:0] sel_value;

    coin_select #(
        .kNumCoins (kNumCoins),
        .kTotalBits(kTotalBits),
        .kCoinVal0 (kCoinVal0),
        .kCoinVal1 (kCoinVal1),
        .kCoinVal2 (kCoinVal2)
    ) u_coin_select (
        .remaining(o_remaining),
        .coin     (sel_coin),
        .valid    (sel_valid)
    );

    // Value of the selected coin; zero when nothing fits.
    always_comb begin
        sel_value = '0;
        if (sel_coin[2]) begin
            sel_value = kTotalBits'(kCoinVal2);
        end else if (sel_coin[1]) begin
            sel_value = kTotalBits'(kCoinVal1);
        end else if (sel_coin[0]) begin
            sel_value = kTotalBits'(kCoinVal0);
        end
    end

    // o_remaining doubles as the owed-amount register so the residue stays visible.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            o_remaining   <= '0;
            o_return_coin <= '0;
            o_done        <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            o_return_coin <= '0;
            o_done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_remaining <= i_amount;
                        o_busy      <= 1'b1;
                        state       <= DISPENSE;
                    end
                end
                DISPENSE: begin
                    if (!sel_valid) begin
                        o_done <= 1'b1;
                        state  <= DONE;
                    end else if (i_hopper_ready) begin
                        o_return_coin <= sel_coin;
                        o_remaining   <= o_remaining - sel_value;
                    end
                end
                DONE: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
